// File: rtl/cvxif_copro_ooo.sv
// CV-X-IF coprocessor for custom-3 ALU ops.
// Tracks in-flight IDs, pipelines execution and completes out of order.
module cvxif_copro_ooo #(
    parameter int XLEN        = 64,
    parameter int IdWidth     = 4,
    parameter int HartIdWidth = 64,
    parameter int Latency     = 2,
    parameter int ResultDepth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   compressed_valid_i,
    input  logic [15:0]            compressed_instr_i,
    output logic                   compressed_ready_o,
    output logic                   compressed_accept_o,
    output logic [31:0]            compressed_instr_o,
    input  logic                   issue_valid_i,
    input  logic [31:0]            issue_instr_i,
    input  logic [HartIdWidth-1:0] issue_hartid_i,
    input  logic [IdWidth-1:0]     issue_id_i,
    output logic                   issue_ready_o,
    output logic                   issue_accept_o,
    output logic                   issue_writeback_o,
    output logic [1:0]             issue_register_read_o,
    input  logic                   register_valid_i,
    input  logic [IdWidth-1:0]     register_id_i,
    input  logic [XLEN-1:0]        register_rs0_i,
    input  logic [XLEN-1:0]        register_rs1_i,
    input  logic [1:0]             register_rs_valid_i,
    output logic                   register_ready_o,
    input  logic                   commit_valid_i,
    input  logic [IdWidth-1:0]     commit_id_i,
    input  logic                   commit_kill_i,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic [HartIdWidth-1:0] result_hartid_o,
    output logic [IdWidth-1:0]     result_id_o,
    output logic [XLEN-1:0]        result_data_o,
    output logic [4:0]             result_rd_o,
    output logic                   result_we_o
);

    localparam int NrEntries = 2 ** IdWidth;
    localparam int PW = (ResultDepth > 1) ? $clog2(ResultDepth) : 1;
    localparam int CW = $clog2(ResultDepth + 1);
    localparam int EW = $clog2(NrEntries + 1);
    localparam int LAST = Latency - 1;

    typedef enum logic [1:0] {
        ST_FREE, ST_ISSUED, ST_OPS, ST_EXEC
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD, OP_SUB, OP_XOR, OP_NOP
    } op_e;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(ResultDepth - 1)) ? '0 : p + PW'(1);
    endfunction

    // in-flight table
    state_e                 state_q [NrEntries];
    state_e                 state_d [NrEntries];
    op_e                    op_q    [NrEntries];
    op_e                    op_d    [NrEntries];
    logic [4:0]             rd_q    [NrEntries];
    logic [4:0]             rd_d    [NrEntries];
    logic [HartIdWidth-1:0] hart_q  [NrEntries];
    logic [HartIdWidth-1:0] hart_d  [NrEntries];
    logic [XLEN-1:0]        rsa_q   [NrEntries];
    logic [XLEN-1:0]        rsa_d   [NrEntries];
    logic [XLEN-1:0]        rsb_q   [NrEntries];
    logic [XLEN-1:0]        rsb_d   [NrEntries];
    logic                   cmt_q   [NrEntries];
    logic                   cmt_d   [NrEntries];
    logic                   kil_q   [NrEntries];
    logic                   kil_d   [NrEntries];

    // execute pipeline
    logic               pv_q   [Latency];
    logic               pv_d   [Latency];
    logic [IdWidth-1:0] pid_q  [Latency];
    logic [IdWidth-1:0] pid_d  [Latency];
    logic [XLEN-1:0]    pdat_q [Latency];
    logic [XLEN-1:0]    pdat_d [Latency];

    // result fifo
    logic [IdWidth-1:0] fid_q  [ResultDepth];
    logic [IdWidth-1:0] fid_d  [ResultDepth];
    logic [XLEN-1:0]    fdat_q [ResultDepth];
    logic [XLEN-1:0]    fdat_d [ResultDepth];
    logic [PW-1:0]      wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               dec_legal, dec_wb;
    op_e                dec_op;
    logic [EW-1:0]      busy;
    logic               disp_v, disp_go;
    logic [IdWidth-1:0] disp_id, hid;
    logic [XLEN-1:0]    alu_res;
    logic               fifo_full, pop, stall;
    logic               last_kill, push, drop;
    logic               unused_in;

    assign unused_in = ^{compressed_valid_i, compressed_instr_i,
                         issue_instr_i[24:15]};

    // Decode of the issued instruction
    always_comb begin
        dec_op    = op_e'(issue_instr_i[13:12]);
        dec_legal = (issue_instr_i[6:0] == 7'h7B)
                 && (issue_instr_i[31:25] == 7'h00)
                 && !issue_instr_i[14];
        dec_wb    = dec_legal && (dec_op != OP_NOP);
    end

    assign compressed_ready_o    = 1'b1;
    assign compressed_accept_o   = 1'b0;
    assign compressed_instr_o    = '0;
    assign issue_accept_o        = dec_legal;
    assign issue_writeback_o     = dec_wb;
    assign issue_register_read_o = dec_wb ? 2'b11 : 2'b00;
    assign register_ready_o      = 1'b1;

    // Count busy entries for issue flow control
    always_comb begin
        busy = '0;
        for (int i = 0; i < NrEntries; i++) begin
            if (state_q[i] != ST_FREE) busy = busy + EW'(1);
        end
    end

    assign issue_ready_o = !rst_i && (busy < EW'(NrEntries));

    // Lowest-index ready entry wins dispatch
    always_comb begin
        disp_v  = 1'b0;
        disp_id = '0;
        for (int i = NrEntries - 1; i >= 0; i--) begin
            if (state_q[i] == ST_OPS && cmt_q[i]
                && op_q[i] != OP_NOP) begin
                disp_v  = 1'b1;
                disp_id = IdWidth'(i);
            end
        end
    end

    // ALU evaluated on the entry being dispatched
    always_comb begin
        alu_res = '0;
        unique case (op_q[disp_id])
            OP_ADD:  alu_res = rsa_q[disp_id] + rsb_q[disp_id];
            OP_SUB:  alu_res = rsa_q[disp_id] - rsb_q[disp_id];
            OP_XOR:  alu_res = rsa_q[disp_id] ^ rsb_q[disp_id];
            default: alu_res = '0;
        endcase
    end

    // Handshake, stall and fifo write decisions
    always_comb begin
        hid       = fid_q[rp_q];
        fifo_full = (cnt_q == CW'(ResultDepth));
        pop       = (cnt_q != '0) && result_ready_i;
        stall     = pv_q[LAST] && fifo_full && !pop;
        disp_go   = disp_v && !stall;
        last_kill = kil_q[pid_q[LAST]]
                 || (commit_valid_i && commit_kill_i
                     && commit_id_i == pid_q[LAST]);
        push      = pv_q[LAST] && !stall && !last_kill;
        drop      = pv_q[LAST] && !stall && last_kill;
    end

    // In-flight table next state
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        hart_d  = hart_q;
        rsa_d   = rsa_q;
        rsb_d   = rsb_q;
        cmt_d   = cmt_q;
        kil_d   = kil_q;
        for (int i = 0; i < NrEntries; i++) begin
            if (issue_valid_i && issue_ready_o && dec_legal
                && issue_id_i == IdWidth'(i)
                && state_q[i] == ST_FREE) begin
                state_d[i] = (dec_op == OP_NOP) ? ST_OPS : ST_ISSUED;
                op_d[i]    = dec_op;
                rd_d[i]    = issue_instr_i[11:7];
                hart_d[i]  = issue_hartid_i;
                cmt_d[i]   = 1'b0;
                kil_d[i]   = 1'b0;
            end
            if (register_valid_i && register_id_i == IdWidth'(i)
                && state_q[i] == ST_ISSUED
                && register_rs_valid_i == 2'b11) begin
                state_d[i] = ST_OPS;
                rsa_d[i]   = register_rs0_i;
                rsb_d[i]   = register_rs1_i;
            end
            if (commit_valid_i && !commit_kill_i
                && commit_id_i == IdWidth'(i)
                && state_q[i] != ST_FREE) begin
                cmt_d[i] = 1'b1;
            end
            if (state_q[i] == ST_OPS && cmt_q[i]
                && op_q[i] == OP_NOP) begin
                state_d[i] = ST_FREE;
            end
            if (disp_go && disp_id == IdWidth'(i)) begin
                state_d[i] = ST_EXEC;
            end
            if (pop && hid == IdWidth'(i)) begin
                state_d[i] = ST_FREE;
            end
            if (drop && pid_q[LAST] == IdWidth'(i)) begin
                state_d[i] = ST_FREE;
            end
            if (commit_valid_i && commit_kill_i
                && commit_id_i == IdWidth'(i)) begin
                if (state_d[i] == ST_EXEC) begin
                    kil_d[i] = 1'b1;
                end else if (state_q[i] == ST_ISSUED
                             || state_q[i] == ST_OPS) begin
                    state_d[i] = ST_FREE;
                end
            end
        end
    end

    // Pipeline advance, held as a whole on stall
    always_comb begin
        pv_d   = pv_q;
        pid_d  = pid_q;
        pdat_d = pdat_q;
        if (!stall) begin
            pv_d[0]   = disp_go;
            pid_d[0]  = disp_id;
            pdat_d[0] = alu_res;
            for (int i = 1; i < Latency; i++) begin
                pv_d[i]   = pv_q[i-1];
                pid_d[i]  = pid_q[i-1];
                pdat_d[i] = pdat_q[i-1];
            end
        end
    end

    // Result fifo pointers and storage
    always_comb begin
        fid_d  = fid_q;
        fdat_d = fdat_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        if (push) begin
            fid_d[wp_q]  = pid_q[LAST];
            fdat_d[wp_q] = pdat_q[LAST];
            wp_d         = ptr_inc(wp_q);
        end
        if (pop) rp_d = ptr_inc(rp_q);
        if (push && !pop) cnt_d = cnt_q + CW'(1);
        if (!push && pop) cnt_d = cnt_q - CW'(1);
    end

    // Control state with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NrEntries; i++) begin
                state_q[i] <= ST_FREE;
                cmt_q[i]   <= 1'b0;
                kil_q[i]   <= 1'b0;
            end
            for (int i = 0; i < Latency; i++) pv_q[i] <= 1'b0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cmt_q   <= cmt_d;
            kil_q   <= kil_d;
            pv_q    <= pv_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
        end
    end

    // Payload storage, qualified by the control state
    always_ff @(posedge clk_i) begin
        op_q   <= op_d;
        rd_q   <= rd_d;
        hart_q <= hart_d;
        rsa_q  <= rsa_d;
        rsb_q  <= rsb_d;
        pid_q  <= pid_d;
        pdat_q <= pdat_d;
        fid_q  <= fid_d;
        fdat_q <= fdat_d;
    end

    // Head of the fifo drives the result port, zero when idle
    always_comb begin
        result_valid_o  = (cnt_q != '0);
        result_we_o     = result_valid_o;
        result_id_o     = result_valid_o ? hid : '0;
        result_data_o   = result_valid_o ? fdat_q[rp_q] : '0;
        result_rd_o     = result_valid_o ? rd_q[hid] : '0;
        result_hartid_o = result_valid_o ? hart_q[hid] : '0;
    end

    // Issuing onto a busy ID is a core protocol error
    always_ff @(posedge clk_i) begin
        if (!rst_i && issue_valid_i && issue_ready_o && dec_legal) begin
            assert (state_q[issue_id_i] == ST_FREE);
        end
    end

endmodule

// File: tb/tb_cvxif_copro_ooo.sv
// Directed bench for cvxif_copro_ooo.
// XLEN=32, IdWidth=2, Latency=2, ResultDepth=2.
module tb_cvxif_copro_ooo;

    localparam int XLEN = 32;
    localparam int IW   = 2;
    localparam int HW   = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            c_valid;
    logic [15:0]     c_instr;
    logic            c_ready, c_accept;
    logic [31:0]     c_instr_o;
    logic            i_valid;
    logic [31:0]     i_instr;
    logic [HW-1:0]   i_hart;
    logic [IW-1:0]   i_id;
    logic            i_ready, i_accept, i_wb;
    logic [1:0]      i_rr;
    logic            r_valid;
    logic [IW-1:0]   r_id;
    logic [XLEN-1:0] r_a, r_b;
    logic [1:0]      r_rsv;
    logic            r_ready;
    logic            k_valid;
    logic [IW-1:0]   k_id;
    logic            k_kill;
    logic            o_valid, o_ready;
    logic [HW-1:0]   o_hart;
    logic [IW-1:0]   o_id;
    logic [XLEN-1:0] o_data;
    logic [4:0]      o_rd;
    logic            o_we;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cvxif_copro_ooo #(
        .XLEN(XLEN), .IdWidth(IW), .HartIdWidth(HW),
        .Latency(2), .ResultDepth(2)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .compressed_valid_i(c_valid),
        .compressed_instr_i(c_instr),
        .compressed_ready_o(c_ready),
        .compressed_accept_o(c_accept),
        .compressed_instr_o(c_instr_o),
        .issue_valid_i(i_valid),
        .issue_instr_i(i_instr),
        .issue_hartid_i(i_hart),
        .issue_id_i(i_id),
        .issue_ready_o(i_ready),
        .issue_accept_o(i_accept),
        .issue_writeback_o(i_wb),
        .issue_register_read_o(i_rr),
        .register_valid_i(r_valid),
        .register_id_i(r_id),
        .register_rs0_i(r_a),
        .register_rs1_i(r_b),
        .register_rs_valid_i(r_rsv),
        .register_ready_o(r_ready),
        .commit_valid_i(k_valid),
        .commit_id_i(k_id),
        .commit_kill_i(k_kill),
        .result_valid_o(o_valid),
        .result_ready_i(o_ready),
        .result_hartid_o(o_hart),
        .result_id_o(o_id),
        .result_data_o(o_data),
        .result_rd_o(o_rd),
        .result_we_o(o_we)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3,
                                       input logic [4:0] rd);
        return {17'h0, f3, rd, 7'h7B};
    endfunction

    function automatic logic [63:0] hart(input logic [1:0] id);
        return 64'hABCD_0000_0000_0000 | 64'(id);
    endfunction

    task automatic dec(input string tag, input logic [31:0] ins,
                       input logic acc, input logic wb,
                       input logic [1:0] rr);
        i_instr = ins;
        #1;
        chk({tag, "_acc"}, 64'(i_accept), 64'(acc));
        chk({tag, "_wb"}, 64'(i_wb), 64'(wb));
        chk({tag, "_rr"}, 64'(i_rr), 64'(rr));
    endtask

    task automatic iss(input logic [1:0] id, input logic [2:0] f3,
                       input logic [4:0] rd);
        i_valid = 1'b1;
        i_instr = mk(f3, rd);
        i_id    = id;
        i_hart  = hart(id);
        tick;
        i_valid = 1'b0;
    endtask

    task automatic rc(input logic rv, input logic [1:0] rid,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic cv, input logic [1:0] cid,
                      input logic ck);
        r_valid = rv;
        r_id    = rid;
        r_a     = a;
        r_b     = b;
        r_rsv   = 2'b11;
        k_valid = cv;
        k_id    = cid;
        k_kill  = ck;
        tick;
        r_valid = 1'b0;
        k_valid = 1'b0;
        k_kill  = 1'b0;
    endtask

    logic [1:0]  gid  [8];
    logic [31:0] gdat [8];
    int          n;
    logic        seen;
    logic [1:0]  eid  [4];
    logic [31:0] edat [4];

    initial begin
        rst = 1'b1;
        c_valid = 1'b0; c_instr = '0;
        i_valid = 1'b0; i_instr = '0; i_hart = '0; i_id = '0;
        r_valid = 1'b0; r_id = '0; r_a = '0; r_b = '0; r_rsv = '0;
        k_valid = 1'b0; k_id = '0; k_kill = 1'b0;
        o_ready = 1'b0;
        tick;
        tick;
        chk("rst_ready", 64'(i_ready), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_rd", 64'(o_rd), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready", 64'(i_ready), 64'd1);

        // compressed path and decode
        c_valid = 1'b1;
        c_instr = 16'h4501;
        #1;
        chk("c_ready", 64'(c_ready), 64'd1);
        chk("c_accept", 64'(c_accept), 64'd0);
        chk("c_instr", 64'(c_instr_o), 64'd0);
        chk("reg_ready", 64'(r_ready), 64'd1);
        c_valid = 1'b0;
        dec("add", mk(3'd0, 5'd5), 1'b1, 1'b1, 2'b11);
        dec("sub", mk(3'd1, 5'd5), 1'b1, 1'b1, 2'b11);
        dec("xor", mk(3'd2, 5'd5), 1'b1, 1'b1, 2'b11);
        dec("nop", mk(3'd3, 5'd0), 1'b1, 1'b0, 2'b00);
        dec("f3_7", mk(3'd7, 5'd5), 1'b0, 1'b0, 2'b00);
        dec("f3_4", mk(3'd4, 5'd5), 1'b0, 1'b0, 2'b00);
        dec("f7", 32'h0200_02FB, 1'b0, 1'b0, 2'b00);
        dec("opc", 32'h0000_02F3, 1'b0, 1'b0, 2'b00);

        // ADD with latency check
        iss(2'd1, 3'd0, 5'd5);
        rc(1'b1, 2'd1, 32'h10, 32'h22, 1'b0, 2'd0, 1'b0);
        rc(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd1, 1'b0);
        chk("add_lat0", 64'(o_valid), 64'd0);
        tick;
        chk("add_lat1", 64'(o_valid), 64'd0);
        tick;
        chk("add_lat2", 64'(o_valid), 64'd0);
        tick;
        chk("add_valid", 64'(o_valid), 64'd1);
        chk("add_id", 64'(o_id), 64'd1);
        chk("add_rd", 64'(o_rd), 64'd5);
        chk("add_data", 64'(o_data), 64'h32);
        chk("add_we", 64'(o_we), 64'd1);
        chk("add_hart", o_hart, 64'hABCD_0000_0000_0001);
        o_ready = 1'b1;
        tick;
        chk("add_pop", 64'(o_valid), 64'd0);
        o_ready = 1'b0;

        // kill before operands
        iss(2'd2, 3'd1, 5'd7);
        rc(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd2, 1'b1);
        rc(1'b1, 2'd2, 32'h5, 32'h3, 1'b0, 2'd0, 1'b0);
        repeat (5) tick;
        chk("kill_nores", 64'(o_valid), 64'd0);
        chk("kill_ready", 64'(i_ready), 64'd1);

        // fill the table
        iss(2'd0, 3'd2, 5'd10);
        iss(2'd1, 3'd2, 5'd11);
        iss(2'd3, 3'd2, 5'd13);
        chk("full_3", 64'(i_ready), 64'd1);
        iss(2'd2, 3'd2, 5'd12);
        chk("full_4", 64'(i_ready), 64'd0);
        rc(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd0, 1'b1);
        chk("full_kill0", 64'(i_ready), 64'd1);
        iss(2'd0, 3'd2, 5'd10);
        chk("full_again", 64'(i_ready), 64'd0);

        // backpressure and out-of-order dispatch
        rc(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd3, 1'b0);
        rc(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd1, 1'b0);
        rc(1'b1, 2'd2, 32'hAAAA_AAAA, 32'h5555_0000,
           1'b0, 2'd0, 1'b0);
        rc(1'b1, 2'd0, 32'hF0F0_0000, 32'h0F0F_0000,
           1'b0, 2'd0, 1'b0);
        rc(1'b1, 2'd3, 32'h0000_00FF, 32'h0000_0F0F,
           1'b1, 2'd2, 1'b0);
        rc(1'b1, 2'd1, 32'h1234_5678, 32'hFFFF_FFFF,
           1'b1, 2'd0, 1'b0);
        tick;
        chk("bp_v0", 64'(o_valid), 64'd0);
        tick;
        chk("bp_v1", 64'(o_valid), 64'd1);
        chk("bp_id", 64'(o_id), 64'd2);
        chk("bp_data", 64'(o_data), 64'hFFFF_AAAA);
        chk("bp_rd", 64'(o_rd), 64'd12);
        repeat (3) tick;
        chk("bp_hold_v", 64'(o_valid), 64'd1);
        chk("bp_hold_id", 64'(o_id), 64'd2);
        chk("bp_hold_d", 64'(o_data), 64'hFFFF_AAAA);
        o_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (o_valid) begin
                if (n < 8) begin
                    gid[n]  = o_id;
                    gdat[n] = o_data;
                end
                n++;
            end
            tick;
        end
        o_ready = 1'b0;
        eid  = '{2'd2, 2'd0, 2'd1, 2'd3};
        edat = '{32'hFFFF_AAAA, 32'hFFFF_0000,
                 32'hEDCB_A987, 32'h0000_0FF0};
        chk("bp_count", 64'(n), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < n) begin
                chk($sformatf("bp_id%0d", k), 64'(gid[k]), 64'(eid[k]));
                chk($sformatf("bp_d%0d", k), 64'(gdat[k]), 64'(edat[k]));
            end
        end
        chk("bp_empty", 64'(o_valid), 64'd0);
        chk("bp_ready", 64'(i_ready), 64'd1);

        // illegal issue and NOP retire
        iss(2'd1, 3'd7, 5'd3);
        chk("ill_ready", 64'(i_ready), 64'd1);
        iss(2'd3, 3'd3, 5'd0);
        rc(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd3, 1'b0);
        repeat (5) tick;
        chk("nop_nores", 64'(o_valid), 64'd0);

        // reset with work in the pipeline
        iss(2'd0, 3'd0, 5'd1);
        iss(2'd1, 3'd0, 5'd2);
        iss(2'd2, 3'd0, 5'd3);
        chk("nop_freed", 64'(i_ready), 64'd1);
        rc(1'b1, 2'd0, 32'h1, 32'h2, 1'b0, 2'd0, 1'b0);
        rc(1'b1, 2'd1, 32'h3, 32'h4, 1'b0, 2'd0, 1'b0);
        rc(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd0, 1'b0);
        rc(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd1, 1'b0);
        tick;
        rst = 1'b1;
        tick;
        chk("mid_rst_v", 64'(o_valid), 64'd0);
        chk("mid_rst_rdy", 64'(i_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", 64'(i_ready), 64'd1);
        o_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (o_valid) seen = 1'b1;
            tick;
        end
        chk("post_rst_nores", 64'(seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
